// File: rtl/fp_sum5_sequencer.sv
// Collects five single-precision words and reduces them to one sum through a shared,
// fixed-latency pipelined FP adder, tracking in-flight adds with a tag pipeline.
module fp_sum5_sequencer #(
  parameter int unsigned ADD_LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [3:0] {
    S_COLLECT, S_ISSUE1, S_ISSUE2, S_WAIT1, S_ISSUE3,
    S_WAIT2, S_ISSUE4, S_WAIT3, S_DONE
  } state_t;

  typedef enum logic [1:0] {T_S01, T_S23, T_S0123, T_SUM} tag_t;

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic [31:0] r_slot [5];
  logic [31:0] r_s01, r_s23, r_s0123;
  logic        r_got01, r_got23;
  logic        r_tag_v [ADD_LAT];
  tag_t        r_tag   [ADD_LAT];
  logic [31:0] r_add_a, r_add_b;
  logic        r_out_valid;
  logic [31:0] r_out_data;

  logic        w_push;
  tag_t        w_push_tag;
  logic [31:0] w_add_a_nxt, w_add_b_nxt;
  logic        w_cap01, w_cap23, w_cap0123, w_capsum;

  assign w_cap01   = r_tag_v[ADD_LAT-1] && (r_tag[ADD_LAT-1] == T_S01);
  assign w_cap23   = r_tag_v[ADD_LAT-1] && (r_tag[ADD_LAT-1] == T_S23);
  assign w_cap0123 = r_tag_v[ADD_LAT-1] && (r_tag[ADD_LAT-1] == T_S0123);
  assign w_capsum  = r_tag_v[ADD_LAT-1] && (r_tag[ADD_LAT-1] == T_SUM);

  assign in_ready  = (r_state == S_COLLECT);
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_comb begin
    w_next      = r_state;
    w_push      = 1'b0;
    w_push_tag  = T_S01;
    w_add_a_nxt = '0;
    w_add_b_nxt = '0;
    case (r_state)
      S_COLLECT: if (in_valid && (r_cnt == 3'd4)) w_next = S_ISSUE1;
      S_ISSUE1:  begin w_push = 1'b1; w_push_tag = T_S01;   w_next = S_ISSUE2; end
      S_ISSUE2:  begin w_push = 1'b1; w_push_tag = T_S23;   w_next = S_WAIT1;  end
      S_WAIT1:   if ((r_got01 || w_cap01) && (r_got23 || w_cap23)) w_next = S_ISSUE3;
      S_ISSUE3:  begin w_push = 1'b1; w_push_tag = T_S0123; w_next = S_WAIT2;  end
      S_WAIT2:   if (w_cap0123) w_next = S_ISSUE4;
      S_ISSUE4:  begin w_push = 1'b1; w_push_tag = T_SUM;   w_next = S_WAIT3;  end
      S_WAIT3:   if (w_capsum) w_next = S_DONE;
      S_DONE:    if (out_ready) w_next = S_COLLECT;
      default:   w_next = S_COLLECT;
    endcase
    // Operands are registered ahead of the issue state; a partial sum captured on the
    // same edge is forwarded straight from add_c.
    case (w_next)
      S_ISSUE1: begin w_add_a_nxt = r_slot[0]; w_add_b_nxt = r_slot[1]; end
      S_ISSUE2: begin w_add_a_nxt = r_slot[2]; w_add_b_nxt = r_slot[3]; end
      S_ISSUE3: begin
        w_add_a_nxt = w_cap01 ? add_c : r_s01;
        w_add_b_nxt = w_cap23 ? add_c : r_s23;
      end
      S_ISSUE4: begin
        w_add_a_nxt = w_cap0123 ? add_c : r_s0123;
        w_add_b_nxt = r_slot[4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_cnt       <= '0;
      for (int unsigned i = 0; i < 5; i++) r_slot[i] <= '0;
      r_s01       <= '0;
      r_s23       <= '0;
      r_s0123     <= '0;
      r_got01     <= 1'b0;
      r_got23     <= 1'b0;
      for (int unsigned i = 0; i < ADD_LAT; i++) begin
        r_tag_v[i] <= 1'b0;
        r_tag[i]   <= T_S01;
      end
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_add_a    <= w_add_a_nxt;
      r_add_b    <= w_add_b_nxt;
      r_tag_v[0] <= w_push;
      r_tag[0]   <= w_push_tag;
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
      if (r_state == S_COLLECT) begin
        r_got01 <= 1'b0;
        r_got23 <= 1'b0;
        if (in_valid) begin
          r_slot[r_cnt] <= in_data;
          r_cnt         <= r_cnt + 3'd1;
        end
      end
      if (w_cap01)   begin r_s01 <= add_c; r_got01 <= 1'b1; end
      if (w_cap23)   begin r_s23 <= add_c; r_got23 <= 1'b1; end
      if (w_cap0123) r_s0123 <= add_c;
      if (w_capsum)  begin r_out_data <= add_c; r_out_valid <= 1'b1; end
      if ((r_state == S_DONE) && out_ready) begin
        r_out_valid <= 1'b0;
        r_cnt       <= '0;
      end
    end
  end

endmodule
